calibration_registers: RTL
==========================

# calibration_registers

Datapath end of the calibration control path. Consumes the one-cycle command pulses from the calibration control FSM and maintains two live threshold registers: the pixel colour threshold and the filter (match-count) threshold. It applies saturating add/subtract and per-register or global resets. It also publishes stable snapshots of both values to the detection pipeline through a valid/ack handshake.

## Interface
Parameters:
- PIXEL_WIDTH, 8, width of pixel threshold
- PIXEL_DEFAULT, 128, pixel threshold value after reset / reset_pixel
- PIXEL_STEP, 8, increment/decrement applied per pixel command
- FILTER_WIDTH, 4, width of filter threshold
- FILTER_DEFAULT, 4, filter threshold value after reset / reset_filter
- FILTER_STEP, 1, increment/decrement applied per filter command

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- enable_pixel_add  in  1  one-cycle pulse: pixel += PIXEL_STEP
- enable_pixel_sub  in  1  one-cycle pulse: pixel -= PIXEL_STEP
- enable_filter_add  in  1  one-cycle pulse: filter += FILTER_STEP
- enable_filter_sub  in  1  one-cycle pulse: filter -= FILTER_STEP
- reset_pixel  in  1  pulse: pixel <= PIXEL_DEFAULT
- reset_filter  in  1  pulse: filter <= FILTER_DEFAULT
- cfg_ack  in  1  consumer accepts the current snapshot
- pixel_live  out  PIXEL_WIDTH  live pixel threshold (for display)
- filter_live  out  FILTER_WIDTH  live filter threshold (for display)
- cfg_pixel  out  PIXEL_WIDTH  published pixel snapshot
- cfg_filter  out  FILTER_WIDTH  published filter snapshot
- cfg_valid  out  1  snapshot pending acknowledgement
- at_limit  out  2  [1] pixel_live is 0 or all-ones; [0] filter_live is 0 or all-ones

## Operation
- Each register is updated independently. Pixel and filter commands in the same cycle are both applied.
- Per-register priority: reset_x > (add and sub both high: no change) > add > sub.
- Arithmetic is unsigned and saturating. The add result clamps to 2^W-1 and the sub result clamps to 0. The computation uses a W+1-bit intermediate for overflow detection.
- The dirty flag is set in the cycle a register actually changes value, and also by any reset_x pulse, even if the value is already at default. An add at max or a sub at 0 does not set dirty.
- The publish FSM has 2 states:
  - IDLE: cfg_valid=0. If dirty: load cfg_pixel/cfg_filter from pixel_live/filter_live, clear dirty, go to PENDING.
  - PENDING: cfg_valid=1. cfg_pixel and cfg_filter are frozen. On cfg_ack, go to IDLE. Commands arriving in PENDING update the live registers and set dirty; they are republished after returning to IDLE.
- cfg_ack in IDLE is ignored.
- Reset values: pixel_live=cfg_pixel=PIXEL_DEFAULT, filter_live=cfg_filter=FILTER_DEFAULT, cfg_valid=0, dirty=0, state=IDLE. at_limit reflects the defaults (2'b00 with default parameters).
- Reset has priority over every command and over cfg_ack in the same cycle.

## Timing
- All outputs are registered except at_limit, which is combinational from the live registers.
- A command pulse sampled at edge N is visible on pixel_live/filter_live after edge N.
- Dirty is set at edge N; IDLE loads the snapshot at edge N+1, and cfg_valid is high from edge N+1. Command-to-publish latency is 2 cycles.
- cfg_ack sampled high at edge M clears cfg_valid after M. If dirty is pending, the next snapshot is loaded at edge M+1, giving a minimum gap of 1 low cycle on cfg_valid.
- Back-to-back command pulses on consecutive cycles are all applied; the pulses are not required to be spaced.
- cfg_ack may be held high continuously. The module then cycles PENDING → IDLE → PENDING while dirty changes keep occurring.

## Test plan
- Reset, then 3× enable_pixel_add → pixel_live = 152 after the third edge. cfg_valid rises 2 cycles after the first pulse with cfg_pixel = 136, and stays at 136 until ack. Ack → one low cycle, then cfg_valid high with cfg_pixel = 152.
- Saturation: 20× enable_filter_add from default 4 → filter_live = 15, at_limit[0] = 1. A further add sets no dirty (cfg_valid stays low after ack). 20× sub → 0, at_limit[0] = 1.
- Simultaneous: enable_pixel_add and enable_pixel_sub together → no change, no publish. reset_pixel together with enable_pixel_add → pixel_live = 128 and dirty is set.
- Pixel and filter commands in the same cycle (pixel_sub, filter_add) → 120 and 5, published in a single snapshot.
- Commands during PENDING: a snapshot holds 136; apply 2× pixel_add while cfg_valid is high → cfg_pixel stays 136 and pixel_live = 152. After ack, the next snapshot is 152.
- reset asserted while in PENDING with cfg_ack high in the same cycle → all outputs return to their reset values, and cfg_valid = 0 next cycle.

Source files
------------

// File: rtl/calibration_registers.sv
`timescale 1ns/1ps
// calibration_registers
//
// Datapath end of the calibration control path. Two live threshold
// registers (pixel colour threshold and filter match-count threshold) are
// adjusted by one-cycle command pulses with saturating add/subtract and
// per-register reset. A two-state publish FSM hands stable snapshots of both
// values to the detection pipeline through a valid/ack handshake.
//
// Ports:
//   clock             in   single clock, rising edge
//   reset             in   synchronous, active-high
//   enable_pixel_add  in   pulse: pixel  += PIXEL_STEP  (saturating)
//   enable_pixel_sub  in   pulse: pixel  -= PIXEL_STEP  (saturating)
//   enable_filter_add in   pulse: filter += FILTER_STEP (saturating)
//   enable_filter_sub in   pulse: filter -= FILTER_STEP (saturating)
//   reset_pixel       in   pulse: pixel  <= PIXEL_DEFAULT
//   reset_filter      in   pulse: filter <= FILTER_DEFAULT
//   cfg_ack           in   consumer accepts the current snapshot
//   pixel_live        out  live pixel threshold
//   filter_live       out  live filter threshold
//   cfg_pixel         out  published pixel snapshot
//   cfg_filter        out  published filter snapshot
//   cfg_valid         out  snapshot pending acknowledgement
//   at_limit          out  [1] pixel_live at 0/max, [0] filter_live at 0/max

module calibration_registers #(
  parameter int unsigned PIXEL_WIDTH    = 8,
  parameter int unsigned PIXEL_DEFAULT  = 128,
  parameter int unsigned PIXEL_STEP     = 8,
  parameter int unsigned FILTER_WIDTH   = 4,
  parameter int unsigned FILTER_DEFAULT = 4,
  parameter int unsigned FILTER_STEP    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable_pixel_add,
  input  logic                    enable_pixel_sub,
  input  logic                    enable_filter_add,
  input  logic                    enable_filter_sub,
  input  logic                    reset_pixel,
  input  logic                    reset_filter,
  input  logic                    cfg_ack,
  output logic [PIXEL_WIDTH-1:0]  pixel_live,
  output logic [FILTER_WIDTH-1:0] filter_live,
  output logic [PIXEL_WIDTH-1:0]  cfg_pixel,
  output logic [FILTER_WIDTH-1:0] cfg_filter,
  output logic                    cfg_valid,
  output logic [1:0]              at_limit
);

  // Steps are widened by one bit so the carry/borrow of the intermediate
  // result directly signals saturation.
  localparam logic [PIXEL_WIDTH:0]    PIXEL_STEP_EXT  = (PIXEL_WIDTH + 1)'(PIXEL_STEP);
  localparam logic [FILTER_WIDTH:0]   FILTER_STEP_EXT = (FILTER_WIDTH + 1)'(FILTER_STEP);
  localparam logic [PIXEL_WIDTH-1:0]  PIXEL_RST       = PIXEL_WIDTH'(PIXEL_DEFAULT);
  localparam logic [FILTER_WIDTH-1:0] FILTER_RST      = FILTER_WIDTH'(FILTER_DEFAULT);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [PIXEL_WIDTH-1:0]  pixel_reg, pixel_next;
  logic [FILTER_WIDTH-1:0] filter_reg, filter_next;
  logic [PIXEL_WIDTH-1:0]  cfg_pixel_reg;
  logic [FILTER_WIDTH-1:0] cfg_filter_reg;
  logic                    dirty_reg, dirty_next;
  logic                    snapshot_load;

  logic [PIXEL_WIDTH:0]    pixel_sum, pixel_diff;
  logic [FILTER_WIDTH:0]   filter_sum, filter_diff;
  logic                    pixel_touch, filter_touch;

  assign pixel_sum   = {1'b0, pixel_reg}  + PIXEL_STEP_EXT;
  assign pixel_diff  = {1'b0, pixel_reg}  - PIXEL_STEP_EXT;
  assign filter_sum  = {1'b0, filter_reg} + FILTER_STEP_EXT;
  assign filter_diff = {1'b0, filter_reg} - FILTER_STEP_EXT;

  // Pixel register next value: reset_pixel > (add&sub: hold) > add > sub.
  always_comb begin
    pixel_next = pixel_reg;
    if (reset_pixel) begin
      pixel_next = PIXEL_RST;
    end else if (enable_pixel_add && enable_pixel_sub) begin
      pixel_next = pixel_reg;
    end else if (enable_pixel_add) begin
      pixel_next = pixel_sum[PIXEL_WIDTH] ? '1 : pixel_sum[PIXEL_WIDTH-1:0];
    end else if (enable_pixel_sub) begin
      pixel_next = pixel_diff[PIXEL_WIDTH] ? '0 : pixel_diff[PIXEL_WIDTH-1:0];
    end
  end

  // Filter register next value, same priority scheme.
  always_comb begin
    filter_next = filter_reg;
    if (reset_filter) begin
      filter_next = FILTER_RST;
    end else if (enable_filter_add && enable_filter_sub) begin
      filter_next = filter_reg;
    end else if (enable_filter_add) begin
      filter_next = filter_sum[FILTER_WIDTH] ? '1 : filter_sum[FILTER_WIDTH-1:0];
    end else if (enable_filter_sub) begin
      filter_next = filter_diff[FILTER_WIDTH] ? '0 : filter_diff[FILTER_WIDTH-1:0];
    end
  end

  // A reset pulse always counts as a change so the consumer sees the
  // default re-published, even when the value did not move. A clamped
  // add/sub leaves the value unchanged and therefore publishes nothing.
  assign pixel_touch  = reset_pixel  || (pixel_next  != pixel_reg);
  assign filter_touch = reset_filter || (filter_next != filter_reg);

  // Publish FSM: IDLE loads a snapshot whenever dirty, PENDING holds it
  // until acknowledged.
  always_comb begin
    state_next    = state_reg;
    snapshot_load = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (dirty_reg) begin
          snapshot_load = 1'b1;
          state_next    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (cfg_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A change landing in the same cycle as a snapshot load is not part of
  // that snapshot (the load samples the pre-update value), so it must
  // keep dirty set for the next round.
  assign dirty_next = (dirty_reg && !snapshot_load) || pixel_touch || filter_touch;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      pixel_reg      <= PIXEL_RST;
      filter_reg     <= FILTER_RST;
      cfg_pixel_reg  <= PIXEL_RST;
      cfg_filter_reg <= FILTER_RST;
      dirty_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pixel_reg  <= pixel_next;
      filter_reg <= filter_next;
      dirty_reg  <= dirty_next;
      if (snapshot_load) begin
        cfg_pixel_reg  <= pixel_reg;
        cfg_filter_reg <= filter_reg;
      end
    end
  end

  assign pixel_live  = pixel_reg;
  assign filter_live = filter_reg;
  assign cfg_pixel   = cfg_pixel_reg;
  assign cfg_filter  = cfg_filter_reg;
  assign cfg_valid   = (state_reg == ST_PENDING);

  assign at_limit[1] = (pixel_reg  == '0) || (pixel_reg  == '1);
  assign at_limit[0] = (filter_reg == '0) || (filter_reg == '1);

endmodule
